// File: rtl/wb_dual_master_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter.
// Master 0 is the instruction-fetch port and master 1 is the data port.
// Both ports share a single-beat slave. A grant is held until the transaction
// ends. A watchdog aborts a grant that the slave never acknowledges.
//
// Handshake: a master requests with cyc & stb. The slave completes the beat by
// raising ack for one cycle while it sees cyc & stb. The arbiter forwards that
// ack only to the granted master. Read data is broadcast to both masters, and
// only ack qualifies it. cyc is the ownership signal: when the granted master
// drops cyc, the grant is released.
module wb_dual_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    // master 0 (instruction fetch)
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    // master 1 (data)
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    // shared slave
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,
    // one-hot grant, doubles as the visible FSM state
    output logic [1:0]              grant_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e               state_q;
    logic [1:0]           grant_q;
    logic                 last_q;    // 0: m0 was served last, 1: m1 was served last
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 req0;
    logic                 req1;
    logic                 tie_m1;
    logic                 own_cyc;
    logic                 own_stb;
    logic                 limit_hit;
    logic                 timeout;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    // On a tie, round-robin favours whoever was not served last. Otherwise the data port wins.
    assign tie_m1    = ROUND_ROBIN ? ~last_q : 1'b1;
    assign limit_hit = WDOG_EN && (cnt_q == CNT_LIMIT);
    // An ack in the limit cycle completes normally, so ack masks the abort.
    assign timeout   = own_cyc & ~s_ack_i & limit_hit;

    // Mirror the granted master onto the slave bus, all zero when idle
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (grant_q[0]) begin
            own_cyc  = m0_cyc_i;
            own_stb  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (grant_q[1]) begin
            own_cyc  = m1_cyc_i;
            own_stb  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end
    end

    // Abort cycle: hide the request from the slave so it cannot complete late.
    assign s_cyc_o   = own_cyc & ~timeout;
    assign s_stb_o   = own_stb & ~timeout;

    assign m0_ack_o  = s_ack_i & grant_q[0];
    assign m1_ack_o  = s_ack_i & grant_q[1];
    assign m0_err_o  = timeout & grant_q[0];
    assign m1_err_o  = timeout & grant_q[1];
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign grant_o   = grant_q;

    // Arbitration FSM: grant, tie-break history and watchdog counter
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req0 && req1) begin
                        if (tie_m1) begin
                            state_q <= GRANT1;
                            grant_q <= 2'b10;
                        end else begin
                            state_q <= GRANT0;
                            grant_q <= 2'b01;
                        end
                    end else if (req0) begin
                        state_q <= GRANT0;
                        grant_q <= 2'b01;
                    end else if (req1) begin
                        state_q <= GRANT1;
                        grant_q <= 2'b10;
                    end
                end
                GRANT0, GRANT1: begin
                    if (!own_cyc) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        cnt_q   <= '0;
                    end else if (s_ack_i || timeout) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        cnt_q   <= '0;
                        last_q  <= (state_q == GRANT1);
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // SEL_WIDTH documents the byte-lane count used by the sel ports
    if (SEL_WIDTH * 8 != DATA_WIDTH) begin : g_bad_width
        initial $error("DATA_WIDTH must be a multiple of 8");
    end
endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Bench for wb_dual_master_arbiter. Instance 0 uses round-robin and instance 1
// uses fixed priority. Both instances use an 8-cycle watchdog.
module tb_wb_dual_master_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 8;

    logic          clk;
    logic          rst_n;
    logic          mcyc[2][2];
    logic          mstb[2][2];
    logic          mwe[2][2];
    logic          mack[2][2];
    logic          merr[2][2];
    logic [SW-1:0] msel[2][2];
    logic [AW-1:0] maddr[2][2];
    logic [DW-1:0] mwdat[2][2];
    logic [DW-1:0] mrdat[2][2];
    logic          scyc[2];
    logic          sstb[2];
    logic          swe[2];
    logic          sack[2];
    logic [SW-1:0] ssel[2];
    logic [AW-1:0] saddr[2];
    logic [DW-1:0] swdat[2];
    logic [DW-1:0] srdat[2];
    logic [1:0]    grant[2];

    int checks;
    int failures;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_dual_master_arbiter #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .ROUND_ROBIN(g == 0), .TIMEOUT_CYCLES(TMO)
        ) dut (
            .sys_clk(clk), .rst_n(rst_n),
            .m0_cyc_i(mcyc[g][0]), .m0_stb_i(mstb[g][0]), .m0_we_i(mwe[g][0]),
            .m0_sel_i(msel[g][0]), .m0_addr_i(maddr[g][0]), .m0_data_i(mwdat[g][0]),
            .m0_data_o(mrdat[g][0]), .m0_ack_o(mack[g][0]), .m0_err_o(merr[g][0]),
            .m1_cyc_i(mcyc[g][1]), .m1_stb_i(mstb[g][1]), .m1_we_i(mwe[g][1]),
            .m1_sel_i(msel[g][1]), .m1_addr_i(maddr[g][1]), .m1_data_i(mwdat[g][1]),
            .m1_data_o(mrdat[g][1]), .m1_ack_o(mack[g][1]), .m1_err_o(merr[g][1]),
            .s_cyc_o(scyc[g]), .s_stb_o(sstb[g]), .s_we_o(swe[g]),
            .s_sel_o(ssel[g]), .s_addr_o(saddr[g]), .s_data_o(swdat[g]),
            .s_data_i(srdat[g]), .s_ack_i(sack[g]), .grant_o(grant[g])
        );
    end

    // {grant[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}
    function automatic logic [7:0] obs_ctrl(input int i);
        return {grant[i], scyc[i], sstb[i], mack[i][0], mack[i][1], merr[i][0], merr[i][1]};
    endfunction

    // driver tasks
    task automatic drive_idle();
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) begin
                mcyc[i][m]  = 1'b0;
                mstb[i][m]  = 1'b0;
                mwe[i][m]   = 1'b0;
                msel[i][m]  = '0;
                maddr[i][m] = '0;
                mwdat[i][m] = '0;
            end
            sack[i]  = 1'b0;
            srdat[i] = '0;
        end
    endtask

    task automatic req(input int i, input int m, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [SW-1:0] sel);
        mcyc[i][m]  = 1'b1;
        mstb[i][m]  = 1'b1;
        mwe[i][m]   = we;
        maddr[i][m] = addr;
        mwdat[i][m] = data;
        msel[i][m]  = sel;
    endtask

    // Leaves the bench at posedge+1 with reset released and all inputs idle.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int m = 0; m < 2; m++) req(i, m, 1'b1, 32'hFFFF_FFF0, 32'hA5A5_A5A5, 4'hF);
            sack[i]  = 1'b1;
            srdat[i] = 32'h0BAD_F00D;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_ctrl(i) !== 8'h00) begin
                failures++;
                $display("FAIL reset_ctrl inst%0d got=%b exp=%b", i, obs_ctrl(i), 8'h00);
            end
            checks++;
            if ({swe[i], ssel[i], saddr[i], swdat[i]} !== 69'h0) begin
                failures++;
                $display("FAIL reset_bus inst%0d got=%h exp=0", i, {swe[i], ssel[i], saddr[i], swdat[i]});
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b1;
        sack[0] = 1'b1;
        sack[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_ctrl(i) !== 8'h00) begin
                failures++;
                $display("FAIL idle_ack_ignored inst%0d got=%b exp=%b", i, obs_ctrl(i), 8'h00);
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic test_single_read();
        apply_reset();
        req(0, 0, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if ({grant[0], sstb[0]} !== 3'b000) begin
            failures++;
            $display("FAIL rd_no_early_stb got=%b exp=000", {grant[0], sstb[0]});
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'b01_1_1_0000 || saddr[0] !== 32'h100 || swe[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_grant ctrl=%b addr=%h we=%b exp ctrl=01110000 addr=100 we=0", obs_ctrl(0), saddr[0], swe[0]);
        end
        @(posedge clk);
        #1;
        sack[0]  = 1'b1;
        srdat[0] = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'b01_1_1_1000) begin
            failures++;
            $display("FAIL rd_ack_ctrl got=%b exp=%b", obs_ctrl(0), 8'b01_1_1_1000);
        end
        checks++;
        if (mrdat[0][0] !== 32'hDEAD_BEEF || mrdat[0][1] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL rd_data got=%h/%h exp=deadbeef", mrdat[0][0], mrdat[0][1]);
        end
        @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'h00) begin
            failures++;
            $display("FAIL rd_release got=%b exp=%b", obs_ctrl(0), 8'h00);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_q[$];
        logic [1:0] got[2][4];
        int         at[2][4];
        int         n[2];
        apply_reset();
        n[0] = 0;
        n[1] = 0;
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 2; m++) req(i, m, 1'b0, 32'h40 + 32'(m * 4), 32'h0, 4'hF);
        for (int c = 0; c < 12; c++) begin
            #1;
            for (int i = 0; i < 2; i++) sack[i] = scyc[i] & sstb[i];
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (grant[i] !== 2'b00 && n[i] < 4) begin
                    got[i][n[i]] = grant[i];
                    at[i][n[i]]  = c;
                    n[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            exp_q.delete();
            // Round-robin alternates, starting with m0 because m1 counts as served last after reset.
            for (int k = 0; k < 4; k++) exp_q.push_back((i == 0 && k % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (n[i] != 4) begin
                failures++;
                $display("FAIL tie_grant_count inst%0d got=%0d exp=4", i, n[i]);
            end
            for (int k = 0; k < n[i]; k++) begin
                checks++;
                if (got[i][k] !== exp_q[k]) begin
                    failures++;
                    $display("FAIL tie_order inst%0d grant%0d got=%b exp=%b", i, k, got[i][k], exp_q[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (at[i][k] - at[i][k-1] != 2) begin
                        failures++;
                        $display("FAIL tie_gap inst%0d grant%0d got=%0d exp=2", i, k, at[i][k] - at[i][k-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_write_hold();
        apply_reset();
        req(0, 1, 1'b1, 32'h2004, 32'h1234_5678, 4'b0011);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'b10_1_1_0000) begin
            failures++;
            $display("FAIL wr_grant got=%b exp=%b", obs_ctrl(0), 8'b10_1_1_0000);
        end
        checks++;
        if ({swe[0], ssel[0], saddr[0], swdat[0]} !== {1'b1, 4'b0011, 32'h2004, 32'h1234_5678}) begin
            failures++;
            $display("FAIL wr_bus got=%h exp=%h", {swe[0], ssel[0], saddr[0], swdat[0]},
                     {1'b1, 4'b0011, 32'h2004, 32'h1234_5678});
        end
        @(posedge clk);
        #1;
        req(0, 0, 1'b0, 32'h300, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (grant[0] !== 2'b10 || mack[0][0] !== 1'b0) begin
                failures++;
                $display("FAIL wr_m0_waits cyc%0d grant=%b ack0=%b exp grant=10 ack0=0", k, grant[0], mack[0][0]);
            end
            @(posedge clk);
            #1;
        end
        sack[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'b10_1_1_0100) begin
            failures++;
            $display("FAIL wr_ack got=%b exp=%b", obs_ctrl(0), 8'b10_1_1_0100);
        end
        @(posedge clk);
        #1;
        sack[0]    = 1'b0;
        mcyc[0][1] = 1'b0;
        mstb[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (grant[0] !== 2'b00) begin
            failures++;
            $display("FAIL wr_idle_gap got=%b exp=00", grant[0]);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (grant[0] !== 2'b01 || saddr[0] !== 32'h300) begin
            failures++;
            $display("FAIL wr_m0_served grant=%b addr=%h exp grant=01 addr=300", grant[0], saddr[0]);
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    // ack_at_limit=0: slave never acks; ack_at_limit=1: ack lands in the limit cycle
    task automatic test_watchdog(input bit ack_at_limit);
        logic [7:0] exp_ctrl;
        apply_reset();
        req(0, 0, 1'b0, 32'h600, 32'h0, 4'hF);
        req(0, 1, 1'b0, 32'h700, 32'h0, 4'hF);
        for (int k = 0; k < TMO; k++) begin
            @(posedge clk);
            #1;
            sack[0] = ack_at_limit && (k == TMO - 1);
            @(negedge clk);
            if (k < TMO - 1)   exp_ctrl = 8'b01_1_1_0000;
            else if (ack_at_limit) exp_ctrl = 8'b01_1_1_1000;
            else               exp_ctrl = 8'b01_0_0_0010;
            checks++;
            if (obs_ctrl(0) !== exp_ctrl) begin
                failures++;
                $display("FAIL wdog%0d_cyc%0d got=%b exp=%b", ack_at_limit, k, obs_ctrl(0), exp_ctrl);
            end
        end
        @(posedge clk);
        #1;
        sack[0]    = 1'b0;
        mcyc[0][0] = 1'b0;
        mstb[0][0] = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'h00) begin
            failures++;
            $display("FAIL wdog%0d_idle got=%b exp=%b", ack_at_limit, obs_ctrl(0), 8'h00);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (grant[0] !== 2'b10 || saddr[0] !== 32'h700) begin
            failures++;
            $display("FAIL wdog%0d_pending_m1 grant=%b addr=%h exp grant=10 addr=700", ack_at_limit, grant[0], saddr[0]);
        end
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic test_abort();
        apply_reset();
        req(0, 0, 1'b0, 32'h500, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (grant[0] !== 2'b01) begin
            failures++;
            $display("FAIL abort_pre grant=%b exp=01", grant[0]);
        end
        @(posedge clk);
        #1;
        sack[0] = 1'b1;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (obs_ctrl(0) !== 8'h00) begin
            failures++;
            $display("FAIL abort_rst got=%b exp=%b", obs_ctrl(0), 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'h00) begin
            failures++;
            $display("FAIL abort_rst_after got=%b exp=%b", obs_ctrl(0), 8'h00);
        end
        @(posedge clk);
        #1;
        req(0, 0, 1'b0, 32'h510, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mcyc[0][0] = 1'b0;
        mstb[0][0] = 1'b0;
        #1;
        checks++;
        if (obs_ctrl(0) !== 8'b01_0_0_0000) begin
            failures++;
            $display("FAIL abort_cyc_drop got=%b exp=%b", obs_ctrl(0), 8'b01_0_0_0000);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs_ctrl(0) !== 8'h00) begin
            failures++;
            $display("FAIL abort_cyc_release got=%b exp=%b", obs_ctrl(0), 8'h00);
        end
    endtask

    // Random traffic on both instances against a transaction-level model
    task automatic test_random();
        int         owner[2];
        int         cnt[2];
        int         last[2];
        logic       active[2][2];
        logic       done[2][2];
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1;
            cnt[i]   = 0;
            last[i]  = 1;
            for (int m = 0; m < 2; m++) begin
                active[i][m] = 1'b0;
                done[i][m]   = 1'b0;
            end
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int m = 0; m < 2; m++) begin
                    if (active[i][m] && (done[i][m] || $urandom_range(0, 49) == 0)) begin
                        mcyc[i][m]   = 1'b0;
                        mstb[i][m]   = 1'b0;
                        active[i][m] = 1'b0;
                    end else if (!active[i][m] && $urandom_range(0, 2) == 0) begin
                        req(i, m, 1'($urandom), $urandom, $urandom, 4'($urandom));
                        active[i][m] = 1'b1;
                        done[i][m]   = 1'b0;
                    end else if (!active[i][m]) begin
                        maddr[i][m] = $urandom;
                    end
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                sack[i]  = scyc[i] & sstb[i] & ($urandom_range(0, 3) == 0);
                srdat[i] = $urandom;
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int          o;
                logic        own_cyc;
                logic        own_stb;
                logic        tmo;
                logic        r0;
                logic        r1;
                logic [68:0] e_bus;
                logic [7:0]  e_ctrl;
                o       = owner[i];
                own_cyc = 1'b0;
                own_stb = 1'b0;
                e_bus   = '0;
                if (o >= 0) begin
                    own_cyc = mcyc[i][o];
                    own_stb = mstb[i][o];
                    e_bus   = {mwe[i][o], msel[i][o], maddr[i][o], mwdat[i][o]};
                end
                tmo    = own_cyc && !sack[i] && (cnt[i] == TMO - 1);
                e_ctrl = {o == 1, o == 0, own_cyc && !tmo, own_stb && !tmo,
                          sack[i] && o == 0, sack[i] && o == 1, tmo && o == 0, tmo && o == 1};
                checks++;
                if (obs_ctrl(i) !== e_ctrl) begin
                    failures++;
                    $display("FAIL rand_ctrl inst%0d cyc%0d got=%b exp=%b", i, c, obs_ctrl(i), e_ctrl);
                end
                checks++;
                if ({swe[i], ssel[i], saddr[i], swdat[i]} !== e_bus) begin
                    failures++;
                    $display("FAIL rand_bus inst%0d cyc%0d got=%h exp=%h", i, c, {swe[i], ssel[i], saddr[i], swdat[i]}, e_bus);
                end
                checks++;
                if ({mrdat[i][0], mrdat[i][1]} !== {srdat[i], srdat[i]}) begin
                    failures++;
                    $display("FAIL rand_rdata inst%0d cyc%0d got=%h exp=%h", i, c, {mrdat[i][0], mrdat[i][1]}, {srdat[i], srdat[i]});
                end
                for (int m = 0; m < 2; m++) done[i][m] = done[i][m] | mack[i][m] | merr[i][m];
                // Model transition on the coming edge.
                if (o < 0) begin
                    r0     = mcyc[i][0] & mstb[i][0];
                    r1     = mcyc[i][1] & mstb[i][1];
                    cnt[i] = 0;
                    if (r0 && r1)  owner[i] = (i == 0) ? 1 - last[i] : 1;
                    else if (r0)   owner[i] = 0;
                    else if (r1)   owner[i] = 1;
                end else if (!own_cyc) begin
                    owner[i] = -1;
                    cnt[i]   = 0;
                end else if (sack[i] || tmo) begin
                    last[i]  = o;
                    owner[i] = -1;
                    cnt[i]   = 0;
                end else begin
                    cnt[i]++;
                end
            end
            @(posedge clk);
            #1;
        end
        drive_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive_idle();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_hold();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_dual_master_arbiter.md
Name: wb_dual_master_arbiter

Overview:
- Shares one single-beat Wishbone classic slave between two Wishbone masters.
- Master 0 is the instruction-fetch port. Master 1 is the data port.
- Used when the core's instruction and data buses must reach one memory, i.e. the configuration without a second memory.
- Performs fixed-priority or round-robin arbitration, holds the grant until the transaction ends, and aborts hung transactions with a watchdog timeout.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width. SEL width = DATA_WIDTH/8.
- ROUND_ROBIN, 1, 1 = round-robin on ties; 0 = master 1 always wins ties.
- TIMEOUT_CYCLES, 255, cycles in a grant state without ack before abort. 0 disables the watchdog. Counter width = clog2(TIMEOUT_CYCLES+1).

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 request.
- m0_sel_i  in  DATA_WIDTH/8  master 0 byte selects.
- m0_addr_i  in  ADDR_WIDTH  master 0 address.
- m0_data_i  in  DATA_WIDTH  master 0 write data.
- m0_data_o  out  DATA_WIDTH  read data to master 0.
- m0_ack_o  out  1  ack to master 0.
- m0_err_o  out  1  timeout error to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave request.
- s_sel_o  out  DATA_WIDTH/8  slave byte selects.
- s_addr_o  out  ADDR_WIDTH  slave address.
- s_data_o  out  DATA_WIDTH  slave write data.
- s_data_i  in  DATA_WIDTH  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  2  one-hot current grant: bit0 = m0, bit1 = m1.

Behaviour:

Reset:
- state = IDLE, grant_o = 0, timeout counter = 0.
- last_grant = m1, so m0 wins the first tie.
- All slave outputs 0; m*_ack_o = 0; m*_err_o = 0.

Request and state machine:
- A master requests when cyc & stb are both high.
- States are IDLE, GRANT0, GRANT1.
- IDLE:
  - Only one master requesting → go to its GRANTn.
  - Both requesting with ROUND_ROBIN=1 → grant the master that is not last_grant.
  - Both requesting with ROUND_ROBIN=0 → grant m1.
  - No request → stay in IDLE.
- GRANTn, checked in priority order:
  - Master n drops cyc → IDLE next cycle. The slave sees cyc fall in the same cycle, because slave cyc is combinational from master cyc and grant.
  - Otherwise s_ack_i=1 → IDLE next cycle; last_grant ← n.
  - Otherwise counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0 → pulse mn_err_o for one cycle, force s_cyc_o/s_stb_o low that cycle, go to IDLE, last_grant ← n.
  - Otherwise stay in GRANTn and increment the counter.
- Counter clears on entry to IDLE.

Latency and muxing:
- Request to s_stb_o: exactly one cycle, because grant is registered.
- The return to IDLE inserts one idle cycle between back-to-back grants.
- Slave outputs mirror the granted master combinationally while in GRANTn; they are all 0 in IDLE.
- mn_ack_o = s_ack_i & grant_o[n]. The ungranted master never sees ack.
- m0_data_o and m1_data_o are both driven by s_data_i (broadcast); only ack qualifies them.

Boundary cases:
- s_ack_i while in IDLE is ignored and not forwarded.
- Ack and timeout in the same cycle: ack wins and err stays 0.
- Ungranted master request is held pending without limit and is served at the next IDLE.
- Asserting rst_n low mid-transaction immediately drops s_cyc_o and s_stb_o; no ack or err is emitted.

Test Plan:
1. Single m0 read, addr 0x100, slave acks on the 2nd cycle with data 0xDEADBEEF → s_stb_o rises 1 cycle after request; m0_ack_o=1 with m0_data_o=0xDEADBEEF; m1_ack_o stays 0; grant_o returns to 0.
2. Simultaneous m0/m1 requests held continuously for 4 transactions, ROUND_ROBIN=1 → grant order m0, m1, m0, m1 with one idle cycle between grants. With ROUND_ROBIN=0 → m1 is granted every time.
3. m1 write, addr 0x2004, data 0x12345678, sel 4'b0011 → s_we_o=1, s_sel_o=0011, s_addr_o/s_data_o match during GRANT1; m0 request arriving mid-transaction waits until after m1_ack_o.
4. TIMEOUT_CYCLES=8, slave never acks m0 → m0_err_o pulses once, s_cyc_o falls, state returns to IDLE; a pending m1 request is granted next.
5. Ack on the same cycle the counter hits its limit → m0_ack_o=1, m0_err_o=0.
6. rst_n driven low mid-grant, and separately m0 dropping cyc mid-grant → s_cyc_o=0 immediately; grant_o=0; no ack or err emitted.
